// File: rtl/ones_pattern_generator_pkg.sv
// Shared constants and FSM encoding for the ones pattern generator.
// Latency: n/a (declarations only). Backpressure: n/a.
package ones_pattern_generator_pkg;

   localparam int PAT_W = 7;
   localparam int PAT_N = (1 << PAT_W) - 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EMIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/OTSBitsCounter.sv
// Combinational population count of a 127-bit word.
// Latency: 0 cycles. Backpressure: none.
module OTSBitsCounter #(
   parameter int N = 127,
   parameter int W = 7
) (
   input  logic [N-1:0] bits,
   output logic [W-1:0] ones
);

   always_comb begin
      ones = '0;
      for (int i = 0; i < N; i++) begin
         ones = ones + W'(bits[i]);
      end
   end

endmodule

// File: rtl/ones_pattern_generator.sv
// Emits an N-bit thermometer frame (count ones, then zeros) serially and assembles it into pattern.
// Latency: bits consumed at edges t+1..t+N after start at edge t; done one cycle later.
// Backpressure: ser_ready low stalls the bit index and holds ser_data.
module ones_pattern_generator
   import ones_pattern_generator_pkg::*;
#(
   parameter int N = PAT_N,
   parameter int W = PAT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] count,
   output logic         busy,
   output logic         ser_data,
   output logic         ser_valid,
   input  logic         ser_ready,
   output logic [N-1:0] pattern,
   output logic         done,
   output logic         check_ok
);

   localparam logic [W-1:0] LAST_IDX = W'(N - 1);

   state_t       state_q;
   state_t       state_d;
   logic [W-1:0] idx_q;
   logic [W-1:0] count_lat_q;
   logic [N-1:0] pattern_q;
   logic [W-1:0] ones_cnt;
   logic         accept;
   logic         consume;
   logic         last_bit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      busy      = 1'b0;
      ser_valid = 1'b0;
      ser_data  = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      consume   = 1'b0;
      last_bit  = (idx_q == LAST_IDX);
      case (state_q)
         ST_IDLE: begin
            // busy rises combinationally with an accepted start, but never while held in reset
            accept = start & rst_n;
            busy   = accept;
            if (accept) begin
               state_d = ST_EMIT;
            end
         end
         ST_EMIT: begin
            busy      = 1'b1;
            ser_valid = 1'b1;
            ser_data  = (idx_q < count_lat_q);
            consume   = ser_ready;
            if (ser_ready && last_bit) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q       <= '0;
         count_lat_q <= '0;
         pattern_q   <= '0;
      end else if (accept) begin
         idx_q       <= '0;
         count_lat_q <= count;
         pattern_q   <= '0;
      end else if (consume) begin
         pattern_q[idx_q] <= ser_data;
         // index parks on the last bit rather than wrapping past N-1
         if (!last_bit) begin
            idx_q <= idx_q + W'(1);
         end
      end
   end

   OTSBitsCounter #(
      .N (N),
      .W (W)
   ) u_ones_cnt (
      .bits (pattern_q),
      .ones (ones_cnt)
   );

   assign pattern  = pattern_q;
   assign check_ok = (ones_cnt == count_lat_q);

endmodule

// File: tb/tb_ones_pattern_generator.sv
// Directed bench for ones_pattern_generator: table of frames plus reset-abort sequence.
module tb_ones_pattern_generator;

   localparam int N = 127;
   localparam int W = 7;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] count = '0;
   logic         ser_ready = 1'b0;
   logic         busy;
   logic         ser_data;
   logic         ser_valid;
   logic [N-1:0] pattern;
   logic         done;
   logic         check_ok;

   int n_checks = 0;
   int n_fail = 0;

   typedef struct {
      logic [W-1:0] cnt;
      bit           rnd;
      bit           inject;
      logic [N-1:0] exp_pat;
      int           exp_ones;
   } vec_t;

   vec_t vecs[7];

   always #5 clk = ~clk;

   ones_pattern_generator #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .count     (count),
      .busy      (busy),
      .ser_data  (ser_data),
      .ser_valid (ser_valid),
      .ser_ready (ser_ready),
      .pattern   (pattern),
      .done      (done),
      .check_ok  (check_ok)
   );

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check_vec(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One frame: start at a negedge, sample each cycle 1 time unit after the negedge.
   task automatic run_frame(input logic [W-1:0] c, input bit rnd, input bit inject,
                            input logic [N-1:0] exp_pat, input int exp_ones);
      logic [N-1:0] rx;
      int           hs;
      int           k;
      int           ones;
      bit           got_done;
      bit           prev_stall;
      logic         prev_data;
      rx = '0; hs = 0; k = 0; ones = 0;
      got_done = 1'b0; prev_stall = 1'b0; prev_data = 1'b0;

      @(negedge clk);
      start = 1'b1; count = c; ser_ready = 1'b1;
      #1;
      check_bit("busy_on_start", busy, 1'b1);
      @(posedge clk);
      while (!got_done && k < 2000) begin
         @(negedge clk);
         k++;
         start = inject && (k == 10);
         count = (inject && k == 10) ? W'(10) : ~c;
         ser_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         #1;
         if (done) begin
            got_done = 1'b1;
         end else if (ser_valid) begin
            if (prev_stall) check_bit("stall_hold", ser_data, prev_data);
            if (ser_ready) begin
               if (hs < N) rx[hs] = ser_data;
               hs++;
            end
            prev_stall = !ser_ready;
            prev_data  = ser_data;
         end
      end
      check_bit("done_seen", done, 1'b1);
      for (int i = 0; i < N; i++) ones += int'(rx[i]);
      check_bit("check_ok", check_ok, 1'b1);
      check_vec("pattern", pattern, exp_pat);
      check_vec("rx_bits", rx, exp_pat);
      check_int("handshakes", hs, N);
      check_int("rx_ones", ones, exp_ones);
      check_bit("valid_drop", ser_valid, 1'b0);
      check_bit("busy_in_done", busy, 1'b1);
      if (!rnd) check_int("done_latency", k, N + 1);
      // a start presented during the DONE cycle must not launch a frame
      if (inject) begin
         start = 1'b1;
         count = W'(9);
      end
      @(negedge clk);
      start = 1'b0;
      #1;
      check_bit("done_once", done, 1'b0);
      check_bit("busy_idle", busy, 1'b0);
      check_bit("idle_no_valid", ser_valid, 1'b0);
      check_vec("pattern_hold", pattern, exp_pat);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{cnt: 7'd5,   rnd: 1'b0, inject: 1'b0, exp_pat: 127'h1F,                   exp_ones: 5};
      vecs[1] = '{cnt: 7'd0,   rnd: 1'b0, inject: 1'b0, exp_pat: 127'h0,                    exp_ones: 0};
      vecs[2] = '{cnt: 7'd127, rnd: 1'b0, inject: 1'b0, exp_pat: {127{1'b1}},               exp_ones: 127};
      vecs[3] = '{cnt: 7'd64,  rnd: 1'b1, inject: 1'b0, exp_pat: 127'hFFFF_FFFF_FFFF_FFFF, exp_ones: 64};
      vecs[4] = '{cnt: 7'd3,   rnd: 1'b0, inject: 1'b1, exp_pat: 127'h7,                    exp_ones: 3};
      vecs[5] = '{cnt: 7'd1,   rnd: 1'b1, inject: 1'b0, exp_pat: 127'h1,                    exp_ones: 1};
      vecs[6] = '{cnt: 7'd126, rnd: 1'b1, inject: 1'b0, exp_pat: {1'b0, {126{1'b1}}},      exp_ones: 126};

      repeat (3) @(negedge clk);
      #1;
      check_bit("rst_busy", busy, 1'b0);
      check_bit("rst_valid", ser_valid, 1'b0);
      check_bit("rst_data", ser_data, 1'b0);
      check_bit("rst_done", done, 1'b0);
      check_vec("rst_pattern", pattern, '0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 7; v++) begin
         run_frame(vecs[v].cnt, vecs[v].rnd, vecs[v].inject, vecs[v].exp_pat, vecs[v].exp_ones);
      end

      // Abort a count=100 frame at idx=50 with an asynchronous reset
      @(negedge clk);
      start = 1'b1; count = 7'd100; ser_ready = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (50) @(posedge clk);
      #2;
      check_bit("pre_abort_valid", ser_valid, 1'b1);
      check_bit("pre_abort_data", ser_data, 1'b1);
      rst_n = 1'b0;
      #1;
      check_bit("abort_busy", busy, 1'b0);
      check_bit("abort_valid", ser_valid, 1'b0);
      check_bit("abort_data", ser_data, 1'b0);
      check_bit("abort_done", done, 1'b0);
      check_vec("abort_pattern", pattern, '0);
      repeat (3) begin
         @(negedge clk);
         #1;
         check_bit("abort_no_done", done, 1'b0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_frame(7'd7, 1'b0, 1'b0, 127'h7F, 7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
